// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among N_REQ requesters,
// with a single-entry registered response (sum, carry, signed overflow, id).
module adder_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_sum,
   output logic                   rsp_carry,
   output logic                   rsp_ovf,
   input  logic                   rsp_ready
);

   logic              r_rsp_valid;
   logic [ID_W-1:0]   r_rsp_id;
   logic [WIDTH-1:0]  r_rsp_sum;
   logic              r_rsp_carry;
   logic              r_rsp_ovf;
   logic [ID_W-1:0]   r_last_grant;

   logic              w_can_issue;
   logic              w_grant_found;
   logic [ID_W-1:0]   w_grant_idx;
   logic [WIDTH-1:0]  w_a;
   logic [WIDTH-1:0]  w_b;
   logic [WIDTH:0]    w_sum_full;
   logic              w_ovf;

   // A full register may be drained and refilled on the same edge.
   assign w_can_issue = ~r_rsp_valid | rsp_ready;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      int v_idx;
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      v_idx         = 0;
      if (w_can_issue && !reset) begin
         for (int k = 1; k <= N_REQ; k++) begin
            v_idx = (int'(r_last_grant) + k) % N_REQ;
            if (!w_grant_found && req_valid[v_idx]) begin
               w_grant_found = 1'b1;
               w_grant_idx   = ID_W'(v_idx);
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (w_grant_found) req_ready[w_grant_idx] = 1'b1;
   end

   assign w_a        = req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
   assign w_b        = req_b[int'(w_grant_idx)*WIDTH +: WIDTH];
   assign w_sum_full = {1'b0, w_a} + {1'b0, w_b};
   assign w_ovf      = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                       (w_sum_full[WIDTH-1] != w_a[WIDTH-1]);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_sum    <= '0;
         r_rsp_carry  <= 1'b0;
         r_rsp_ovf    <= 1'b0;
         r_last_grant <= ID_W'(N_REQ - 1);
      end else if (w_grant_found) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_id     <= w_grant_idx;
         r_rsp_sum    <= w_sum_full[WIDTH-1:0];
         r_rsp_carry  <= w_sum_full[WIDTH];
         r_rsp_ovf    <= w_ovf;
         r_last_grant <= w_grant_idx;
      end else if (rsp_ready) begin
         r_rsp_valid  <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_sum   = r_rsp_sum;
   assign rsp_carry = r_rsp_carry;
   assign rsp_ovf   = r_rsp_ovf;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

- Round-robin arbiter and sequencer that shares one 32-bit adder datapath between up to `N_REQ` requesters.
- Accepts one add request per cycle through a valid/ready handshake.
- Computes the sum, carry and signed overflow, and returns the result tagged with the requester ID through a single-entry registered response port.
- Sits between the ALU-side clients (PC increment, branch target, address generation) and the shared adder. It replaces per-client adders.

## Interface

- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 32: operand and sum width.
- `ID_W`, default 2: requester ID width, equal to clog2(`N_REQ`).
- `clk`  in  1: rising-edge clock. This is the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  N_REQ: per-requester request valid.
- `req_a`  in  N_REQ*WIDTH: operand A. Requester i uses bits [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH: operand B, same packing as `req_a`.
- `req_ready`  out  N_REQ: one-hot grant, or all zero. Combinational.
- `rsp_valid`  out  1: response register holds a result.
- `rsp_id`  out  ID_W: index of the requester that issued the result.
- `rsp_sum`  out  WIDTH: (a + b) mod 2^WIDTH.
- `rsp_carry`  out  1: unsigned carry out, bit WIDTH of the full sum.
- `rsp_ovf`  out  1: signed overflow. Set when a and b have the same sign and the sum's sign differs.
- `rsp_ready`  in  1: consumer accepts the response.

## Operation

- Output register states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- `can_issue` = EMPTY, or (FULL and `rsp_ready`). The second case is a same-cycle drain and refill.
- Arbitration, only when `can_issue`:
  - Search `req_valid` starting at index (`last_grant`+1) mod `N_REQ` and wrapping.
  - The first valid index i gets `req_ready[i]`=1.
  - No valid requests, or not `can_issue`: `req_ready`=0.
- Transfer happens when `req_valid[i]` and `req_ready[i]` are both high. On that edge:
  - `rsp_sum`, `rsp_carry`, `rsp_ovf` take the values computed from `req_a[i]` and `req_b[i]`.
  - `rsp_id` ← i, `rsp_valid` ← 1, `last_grant` ← i.
- FULL, `rsp_ready`=1, no transfer: go to EMPTY. `rsp_valid` ← 0 and the data fields hold their values.
- FULL, `rsp_ready`=0: all response fields hold and `req_ready`=0. This is backpressure.
- Requester rules:
  - Once `req_valid[i]` is raised it stays high, with stable operands, until its transfer.
  - `req_valid` without a grant is never dropped by the arbiter; it waits.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,… A requester waits at most `N_REQ`-1 transfers.
- Arithmetic:
  - Width is WIDTH+1 internally. The sum is truncated to WIDTH.
  - Operands are treated as raw bits. Signedness matters only for `rsp_ovf`.
- `last_grant` updates only on a transfer, not on arbitration cycles without one.

## Timing

- Reset, applied at a `clk` edge with `reset`=1:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_carry`=0, `rsp_ovf`=0.
  - `last_grant`=`N_REQ`-1, so requester 0 has first priority.
  - `req_ready`=0 while `reset` is high.
- Reset mid-operation discards any held response without handshake. In-flight requests must be re-arbitrated after reset.
- Latency: a transfer at edge k gives `rsp_valid`=1 and valid data after edge k.
- Throughput: 1 result per cycle while `rsp_ready`=1.
- `req_ready` depends combinationally on `req_valid`, `rsp_valid`, `rsp_ready` and `last_grant`. There is no combinational path from `req_a`/`req_b` to any output except through the register.
- Response data is stable while `rsp_valid`=1 and `rsp_ready`=0.

## Test plan

- Reset, then only req 2 valid with a=25, b=30:
  - `req_ready`=4'b0100 in the same cycle.
  - Next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_sum`=55, `rsp_carry`=0, `rsp_ovf`=0.
- All 4 requesters valid, `rsp_ready` tied to 1, for 8 cycles: `rsp_id` sequence is 0,1,2,3,0,1,2,3 with one result every cycle.
- Req 0 with a=32'hFFFF_FFFF, b=1: sum 0, carry 1, ovf 0. Req 1 with a=32'h7FFF_FFFF, b=1: sum 32'h8000_0000, carry 0, ovf 1. Req 3 with a=100, b=-50: sum 50, carry 1, ovf 0.
- Backpressure: result held, `rsp_ready`=0 for 3 cycles with reqs 1 and 3 pending.
  - `req_ready`=0 and the response fields are unchanged for those 3 cycles.
  - When `rsp_ready`=1, the old result drains and the next grant goes to the requester after `last_grant` in that same cycle.
- `reset` asserted while FULL with `rsp_ready`=0: next cycle `rsp_valid`=0, all fields 0, and the following first grant goes to the lowest-index valid requester.
